alu_op_issue: RTL and testbench
===============================

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
- REQ-001: Parameter OPCODE_LENGTH, default 4, is the width of the ALU operation code.
- REQ-002: Parameter TAG_WIDTH, default 32, is the width of the pass-through tag (normally PC).
- REQ-003: clk  input  1  single clock, rising edge.
- REQ-004: reset  input  1  synchronous, active-low reset.
- REQ-005: in_valid  input  1  instruction offered.
- REQ-006: in_ready  output  1  block accepts an instruction this cycle.
- REQ-007: in_instr  input  32  RV32I instruction word.
- REQ-008: in_tag  input  TAG_WIDTH  carried unchanged to out_tag.
- REQ-009: out_valid  output  1  head entry valid.
- REQ-010: out_ready  input  1  consumer (ALU stage) accepts head.
- REQ-011: out_op  output  OPCODE_LENGTH  ALU Operation code.
- REQ-012: out_illegal  output  1  instruction not decodable.
- REQ-013: out_tag  output  TAG_WIDTH  tag of head entry.

Function
- REQ-014: Decode SHALL use these codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, SLT 1100, ADDI 1101, SLTI 1110.
- REQ-015: OP (0110011) SHALL map f3/f7 as follows: 000/0x00 ADD, 000/0x20 SUB, 111 AND, 110 OR, 100 XOR, 001 SLL, 101/0x00 SRL, 101/0x20 SRA, 010 SLT.
- REQ-016: OP-IMM (0010011) SHALL map as follows: 000 ADDI, 010 SLTI, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL/SRA by f7 bit 30.
- REQ-017: BRANCH (1100011) SHALL map f3 000/001 to EQ and f3 100 to SLT.
- REQ-018: LOAD, STORE, JAL, JALR, LUI and AUIPC SHALL map to ADD.
- REQ-019: Any other opcode/f3/f7 combination is illegal (e.g. SLTU, BGEU, f7 not 0x00/0x20).
- REQ-020: The buffer SHALL be a 2-entry FIFO with states EMPTY, ONE, FULL, storing {op, illegal, tag}.
- REQ-021: Push SHALL occur when in_valid&&in_ready; pop SHALL occur when out_valid&&out_ready.
- REQ-022: in_ready SHALL equal (state != FULL); out_valid SHALL equal (state != EMPTY).
- REQ-023: Transitions are as follows. EMPTY+push->ONE. ONE+push only->FULL. ONE+pop only->EMPTY. ONE+push+pop->ONE with the new entry at head. FULL+pop->ONE. All other cases hold state.
- REQ-024: Latency SHALL be 1 cycle: an entry pushed at edge N is visible on out_* after edge N with out_valid=1.
- REQ-025: Sustained throughput SHALL be 1 instruction/cycle when out_ready stays high.
- REQ-026: Ordering SHALL be strict FIFO, and no entry is ever dropped or duplicated.
- REQ-027: out_* SHALL be stable while out_valid=1 and out_ready=0.

Reset
- REQ-028: While reset=0, at each clk edge the block SHALL go to EMPTY and clear out_op, out_illegal and out_tag to 0.
- REQ-029: Pushes and pops SHALL be ignored while reset=0.
- REQ-030: Reset asserted in any state, including FULL, SHALL discard all entries.

Configuration
- REQ-031: With ALU_OP_ILLEGAL_EN defined, an illegal instruction SHALL produce out_illegal=1 and out_op=0000.
- REQ-032: Without ALU_OP_ILLEGAL_EN, out_illegal SHALL be tied 0 and illegal instructions SHALL produce out_op=0010 (ADD).

Structure
- REQ-033: The shared package alu_op_pkg SHALL hold the 4-bit operation-code constants, the RV32I opcode constants, the f3/f7 constants and the FIFO state enum.
- REQ-034: Decoding SHALL be a combinational sub-module alu_op_decode (instr in; op and illegal out), instantiated once in front of the FIFO.

Verification
- REQ-035: Push 0x002081B3 (add) into EMPTY with out_ready=1 -> next cycle out_valid=1, out_op=0010, out_tag=in_tag.
- REQ-036: Push 0x402081B3 then 0x4020D193 back-to-back -> out_op 0110, then 0111 on consecutive cycles.
- REQ-037: out_ready=0 while pushing tags 1,2,3 -> in_ready=0 after two pushes and tag 3 is held off; release out_ready -> tags 1,2,3 are output in order.
- REQ-038: Push 0x0020B1B3 (sltu) -> with macro: out_illegal=1, out_op=0000; without macro: out_illegal=0, out_op=0010.
- REQ-039: Reach FULL, then drive reset=0 for one edge -> out_valid=0, in_ready=1, out_op=0 afterwards.
- REQ-040: In ONE, push and pop in the same cycle -> state stays ONE and the new entry is at head the next cycle.

Source files
------------

// File: rtl/alu_op_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_pkg
// Shared constants for the ALU operation issue block:
//   - 4-bit ALU operation codes produced by the decoder
//   - RV32I major opcodes, funct3 and funct7 field values
//   - state enum of the 2-entry issue FIFO
// Build option: ALU_OP_ILLEGAL_EN (see alu_op_decode / alu_op_issue).
// -----------------------------------------------------------------------------
package alu_op_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_EQ   = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_ADDI = 4'b1101;
    localparam logic [3:0] ALU_SLTI = 4'b1110;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 values (instr[14:12])
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;

    // funct7 values (instr[31:25])
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Issue FIFO occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Combinational RV32I instruction -> ALU operation code decoder.
// Ports:
//   instr   [31:0]  RV32I instruction word
//   op      [3:0]   ALU operation code
//   illegal         instruction is not decodable
// Build option ALU_OP_ILLEGAL_EN:
//   defined   -> undecodable instructions give illegal=1, op=AND (0000)
//   undefined -> illegal is tied 0 and undecodable instructions give op=ADD
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_op_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  op,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] op_raw;
    logic       ill_raw;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Register and immediate fields play no part in choosing the ALU operation.
    logic unused_fields;
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        op_raw  = ALU_ADD;
        ill_raw = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (f3)
                    F3_ADD_SUB: begin
                        if (f7 == F7_BASE)     op_raw = ALU_ADD;
                        else if (f7 == F7_ALT) op_raw = ALU_SUB;
                        else                   ill_raw = 1'b1;
                    end
                    F3_SRL_SRA: begin
                        if (f7 == F7_BASE)     op_raw = ALU_SRL;
                        else if (f7 == F7_ALT) op_raw = ALU_SRA;
                        else                   ill_raw = 1'b1;
                    end
                    F3_SLTU: ill_raw = 1'b1;
                    default: begin
                        // Remaining register ops have no alternate funct7 encoding.
                        if (f7 != F7_BASE) begin
                            ill_raw = 1'b1;
                        end else begin
                            case (f3)
                                F3_AND:  op_raw = ALU_AND;
                                F3_OR:   op_raw = ALU_OR;
                                F3_XOR:  op_raw = ALU_XOR;
                                F3_SLL:  op_raw = ALU_SLL;
                                F3_SLT:  op_raw = ALU_SLT;
                                default: ill_raw = 1'b1;
                            endcase
                        end
                    end
                endcase
            end
            OPC_OP_IMM: begin
                case (f3)
                    F3_ADD_SUB: op_raw = ALU_ADDI;
                    F3_SLT:     op_raw = ALU_SLTI;
                    F3_XOR:     op_raw = ALU_XOR;
                    F3_OR:      op_raw = ALU_OR;
                    F3_AND:     op_raw = ALU_AND;
                    F3_SLL:     op_raw = ALU_SLL;
                    // Arithmetic vs logical right shift selected by instr[30].
                    F3_SRL_SRA: op_raw = instr[30] ? ALU_SRA : ALU_SRL;
                    default:    ill_raw = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                case (f3)
                    F3_BEQ, F3_BNE: op_raw = ALU_EQ;
                    F3_BLT:         op_raw = ALU_SLT;
                    default:        ill_raw = 1'b1;
                endcase
            end
            // Address / link / upper-immediate computations all use the adder.
            OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
                op_raw = ALU_ADD;
            end
            default: ill_raw = 1'b1;
        endcase
    end

`ifdef ALU_OP_ILLEGAL_EN
    assign illegal = ill_raw;
    assign op      = ill_raw ? ALU_AND : op_raw;
`else
    assign illegal = 1'b0;
    assign op      = ill_raw ? ALU_ADD : op_raw;
`endif

endmodule

// File: rtl/alu_op_issue.sv
// -----------------------------------------------------------------------------
// alu_op_issue
// Decodes RV32I instructions into ALU operation codes and queues them in a
// 2-entry FIFO in front of the ALU stage, with valid/ready handshakes on both
// sides. The head entry is held in registers that drive out_* directly.
// Parameters:
//   OPCODE_LENGTH  width of out_op (default 4)
//   TAG_WIDTH      width of the pass-through tag (default 32, normally PC)
// Ports:
//   clk, reset     clock; synchronous active-low reset
//   in_valid/in_ready, in_instr, in_tag         instruction input handshake
//   out_valid/out_ready, out_op, out_illegal, out_tag   head entry output
// Build option ALU_OP_ILLEGAL_EN: when defined, undecodable instructions are
// flagged on out_illegal; otherwise out_illegal is tied 0.
// -----------------------------------------------------------------------------
module alu_op_issue
    import alu_op_pkg::*;
#(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_op,
    output logic                     out_illegal,
    output logic [TAG_WIDTH-1:0]     out_tag
);

    logic [3:0]               dec_op;
    logic                     dec_illegal;
    logic [OPCODE_LENGTH-1:0] new_op;

    alu_op_decode u_decode (
        .instr   (in_instr),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    assign new_op = OPCODE_LENGTH'(dec_op);

    fifo_state_t              state_reg;
    logic [OPCODE_LENGTH-1:0] head_op_reg,  tail_op_reg;
    logic                     head_ill_reg, tail_ill_reg;
    logic [TAG_WIDTH-1:0]     head_tag_reg, tail_tag_reg;

    logic push;
    logic pop;

    assign in_ready  = (state_reg != ST_FULL);
    assign out_valid = (state_reg != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head slot is always the oldest entry; tail slot is only occupied in FULL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_EMPTY;
            head_op_reg  <= '0;
            head_ill_reg <= 1'b0;
            head_tag_reg <= '0;
            tail_op_reg  <= '0;
            tail_ill_reg <= 1'b0;
            tail_tag_reg <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (push) begin
                        head_op_reg  <= new_op;
                        head_ill_reg <= dec_illegal;
                        head_tag_reg <= in_tag;
                        state_reg    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        // Head leaves as the new entry arrives: it becomes head.
                        head_op_reg  <= new_op;
                        head_ill_reg <= dec_illegal;
                        head_tag_reg <= in_tag;
                    end else if (push) begin
                        tail_op_reg  <= new_op;
                        tail_ill_reg <= dec_illegal;
                        tail_tag_reg <= in_tag;
                        state_reg    <= ST_FULL;
                    end else if (pop) begin
                        state_reg    <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_op_reg  <= tail_op_reg;
                        head_ill_reg <= tail_ill_reg;
                        head_tag_reg <= tail_tag_reg;
                        state_reg    <= ST_ONE;
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

    assign out_op  = head_op_reg;
    assign out_tag = head_tag_reg;

`ifdef ALU_OP_ILLEGAL_EN
    assign out_illegal = head_ill_reg;
`else
    assign out_illegal = 1'b0;
    // Flag is always 0 from the decoder in this build; the register is dropped.
    logic unused_ill;
    assign unused_ill = head_ill_reg;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issue
// Directed scenarios followed by random traffic against alu_op_issue. The
// expected FIFO contents are kept in a queue; expected op codes come from a
// table of instruction kinds (mnemonic -> code).
// -----------------------------------------------------------------------------
module tb_alu_op_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic        out_illegal;
    logic [31:0] out_tag;

    alu_op_issue #(
        .OPCODE_LENGTH (4),
        .TAG_WIDTH     (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        ill;
        logic [31:0] tag;
    } entry_t;

    entry_t q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Expected result for an undecodable instruction in this build.
    task automatic illegal_result(output logic [3:0] op, output logic ill);
`ifdef ALU_OP_ILLEGAL_EN
        op = 4'b0000; ill = 1'b1;
`else
        op = 4'b0010; ill = 1'b0;
`endif
    endtask

    // Build a random instruction of the given kind and its expected decode.
    task automatic make_instr(input int kind, output logic [31:0] instr,
                              output logic [3:0] op, output logic ill);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         set_f7;
        bit         bad;
        logic [6:0] addr_opcs [6];
        logic [6:0] junk_opcs [3];
        addr_opcs = '{7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        junk_opcs = '{7'b0001111, 7'b1110011, 7'b0000000};
        set_f7 = 1'b1; f7 = 7'h00; bad = 1'b0; op = 4'b0010; f3 = 3'($urandom);
        opc = 7'b0110011;
        case (kind)
            0:  begin f3 = 3'd0; op = 4'b0010; end               // add
            1:  begin f3 = 3'd0; f7 = 7'h20; op = 4'b0110; end   // sub
            2:  begin f3 = 3'd7; op = 4'b0000; end               // and
            3:  begin f3 = 3'd6; op = 4'b0001; end               // or
            4:  begin f3 = 3'd4; op = 4'b0011; end               // xor
            5:  begin f3 = 3'd1; op = 4'b0100; end               // sll
            6:  begin f3 = 3'd5; op = 4'b0101; end               // srl
            7:  begin f3 = 3'd5; f7 = 7'h20; op = 4'b0111; end   // sra
            8:  begin f3 = 3'd2; op = 4'b1100; end               // slt
            9:  begin f3 = 3'd3; bad = 1'b1; end                 // sltu
            10: begin f7 = 7'h01; bad = 1'b1; end                // bad funct7
            11: begin opc = 7'b0010011; f3 = 3'd0; set_f7 = 0; op = 4'b1101; end // addi
            12: begin opc = 7'b0010011; f3 = 3'd2; set_f7 = 0; op = 4'b1110; end // slti
            13: begin opc = 7'b0010011; f3 = 3'd4; set_f7 = 0; op = 4'b0011; end // xori
            14: begin opc = 7'b0010011; f3 = 3'd6; set_f7 = 0; op = 4'b0001; end // ori
            15: begin opc = 7'b0010011; f3 = 3'd7; set_f7 = 0; op = 4'b0000; end // andi
            16: begin opc = 7'b0010011; f3 = 3'd1; op = 4'b0100; end              // slli
            17: begin opc = 7'b0010011; f3 = 3'd5; op = 4'b0101; end              // srli
            18: begin opc = 7'b0010011; f3 = 3'd5; f7 = 7'h20; op = 4'b0111; end // srai
            19: begin opc = 7'b0010011; f3 = 3'd3; set_f7 = 0; bad = 1'b1; end   // sltiu
            20: begin opc = 7'b1100011; f3 = 3'd0; set_f7 = 0; op = 4'b1000; end // beq
            21: begin opc = 7'b1100011; f3 = 3'd1; set_f7 = 0; op = 4'b1000; end // bne
            22: begin opc = 7'b1100011; f3 = 3'd4; set_f7 = 0; op = 4'b1100; end // blt
            23: begin opc = 7'b1100011; f3 = 3'($urandom_range(5, 7)); set_f7 = 0; bad = 1'b1; end // bge/bltu/bgeu
            24: begin opc = addr_opcs[$urandom_range(0, 5)]; set_f7 = 0; op = 4'b0010; end
            default: begin opc = junk_opcs[$urandom_range(0, 2)]; set_f7 = 0; bad = 1'b1; end
        endcase
        instr = $urandom;
        instr[6:0]   = opc;
        instr[14:12] = f3;
        if (set_f7) instr[31:25] = f7;
        ill = 1'b0;
        if (bad) illegal_result(op, ill);
    endtask

    task automatic check_outputs();
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_op", {28'd0, out_op}, {28'd0, q[0].op});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
            chk("out_tag", out_tag, q[0].tag);
        end
    endtask

    // One clock: drive inputs (at a negedge), apply the model at the
    // posedge, then check outputs at the following negedge.
    task automatic step(input bit rst_n, input bit v, input logic [31:0] instr,
                        input logic [3:0] eop, input bit eill,
                        input logic [31:0] tag, input bit ordy,
                        output bit accepted);
        bit     can_push;
        bit     do_pop;
        entry_t e;
        reset = rst_n; in_valid = v; in_instr = instr; in_tag = tag; out_ready = ordy;
        can_push = (q.size() < 2);
        @(posedge clk);
        accepted = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else begin
            do_pop = ordy && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (v && can_push) begin
                e.op = eop; e.ill = eill; e.tag = tag;
                q.push_back(e);
                accepted = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs();
        $display("t=%0t rst=%0b v=%0b instr=%08h tag=%0h ordy=%0b acc=%0b | out_v=%0b op=%0h ill=%0b tag=%0h depth=%0d",
                 $time, rst_n, v, instr, tag, ordy, accepted, out_valid, out_op, out_illegal, out_tag, q.size());
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({name, "_out_op"}, {28'd0, out_op}, 32'd0);
        chk({name, "_out_illegal"}, {31'd0, out_illegal}, 32'd0);
        chk({name, "_out_tag"}, out_tag, 32'd0);
    endtask

    initial begin
        bit          acc;
        logic [31:0] instr;
        logic [3:0]  eop;
        logic        eill;
        int          guard;

        reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset, with a push offered that must be ignored.
        step(0, 1, 32'h002081B3, 4'h2, 0, 32'hDEAD, 1, acc);
        step(0, 0, 32'h0, 4'h0, 0, 32'h0, 0, acc);
        check_cleared("reset");

        // add into EMPTY, visible one cycle later.
        step(1, 1, 32'h002081B3, 4'b0010, 0, 32'h1000, 1, acc);
        chk("add_op", {28'd0, out_op}, 32'h2);
        step(1, 0, 32'h0, 4'h0, 0, 32'h0, 1, acc);

        // sub then sra back to back.
        step(1, 1, 32'h402081B3, 4'b0110, 0, 32'h1004, 1, acc);
        chk("sub_op", {28'd0, out_op}, 32'h6);
        step(1, 1, 32'h4020D193, 4'b0111, 0, 32'h1008, 1, acc);
        chk("srai_op", {28'd0, out_op}, 32'h7);
        step(1, 0, 32'h0, 4'h0, 0, 32'h0, 1, acc);

        // Backpressure: tags 1,2 fill the FIFO, tag 3 held off.
        step(1, 1, 32'h002081B3, 4'b0010, 0, 32'd1, 0, acc);
        step(1, 1, 32'h002081B3, 4'b0010, 0, 32'd2, 0, acc);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        step(1, 1, 32'h002081B3, 4'b0010, 0, 32'd3, 0, acc);
        chk("tag3_held", {31'd0, acc}, 32'd0);
        chk("head_tag1_held", out_tag, 32'd1);
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 10) begin
            step(1, 1, 32'h002081B3, 4'b0010, 0, 32'd3, 1, acc);
            guard++;
        end
        chk("tag3_accepted", {31'd0, acc}, 32'd1);
        step(1, 0, 32'h0, 4'h0, 0, 32'h0, 1, acc);
        step(1, 0, 32'h0, 4'h0, 0, 32'h0, 1, acc);
        chk("drained", {31'd0, out_valid}, 32'd0);

        // sltu: illegal handling depends on build option.
        illegal_result(eop, eill);
        step(1, 1, 32'h0020B1B3, eop, eill, 32'h2000, 0, acc);
        chk("sltu_op", {28'd0, out_op}, {28'd0, eop});
        chk("sltu_ill", {31'd0, out_illegal}, {31'd0, eill});

        // ONE with push and pop in the same cycle: new entry at head.
        step(1, 1, 32'h0000A1B3, 4'b1100, 0, 32'h2004, 1, acc);
        chk("one_pushpop_valid", {31'd0, out_valid}, 32'd1);
        chk("one_pushpop_tag", out_tag, 32'h2004);

        // Fill, then reset from FULL.
        step(1, 1, 32'h0020F1B3, 4'b0000, 0, 32'h2008, 0, acc);
        chk("full_before_reset", {31'd0, in_ready}, 32'd0);
        step(0, 0, 32'h0, 4'h0, 0, 32'h0, 0, acc);
        check_cleared("reset_full");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            make_instr($urandom_range(0, 25), instr, eop, eill);
            step(1, $urandom_range(0, 3) != 0, instr, eop, eill, $urandom,
                 $urandom_range(0, 3) != 0, acc);
        end

        // Drain.
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 4'h0, 0, 32'h0, 1, acc);
        chk("final_empty", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
